// File: rtl/tester_sequencer.sv
// Runs NUM_TESTS sub-testers one after another (start pulse, wait for done or timeout) and
// raises a single aggregated finish/pass once the sequence ends.
module tester_sequencer #(
  parameter int unsigned NUM_TESTS    = 4,
  parameter int unsigned IDX_W        = 2,
  parameter int unsigned TIMEOUT      = 1024,
  parameter int unsigned CNT_W        = 11,
  parameter bit          STOP_ON_FAIL = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 go,
  output logic [NUM_TESTS-1:0] test_start,
  output logic [NUM_TESTS-1:0] test_busy,
  input  logic [NUM_TESTS-1:0] test_done,
  input  logic [NUM_TESTS-1:0] test_fail,
  output logic [IDX_W-1:0]     cur_idx,
  output logic                 finish,
  output logic                 pass,
  output logic [NUM_TESTS-1:0] fail_mask,
  output logic [NUM_TESTS-1:0] timeout_mask
);

  typedef enum logic [2:0] {StIdle, StLaunch, StWait, StNext, StDone} state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IdxLast = IDX_W'(NUM_TESTS - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_TESTS-1:0] fail_q, fail_d;
  logic [NUM_TESTS-1:0] tmo_q, tmo_d;
  logic [NUM_TESTS-1:0] cur_onehot;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      fail_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      StIdle: begin
        if (go) begin
          state_d = StLaunch;
          idx_d   = '0;
        end
      end
      StLaunch: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // A done arriving on the final allowed cycle still beats the timeout.
        if (test_done[idx_q]) begin
          fail_d[idx_q] = test_fail[idx_q];
          state_d       = StNext;
        end else if (cnt_q == CntLast) begin
          fail_d[idx_q] = 1'b1;
          tmo_d[idx_q]  = 1'b1;
          state_d       = StNext;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StNext: begin
        if (idx_q == IdxLast || (STOP_ON_FAIL && fail_q[idx_q])) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = StLaunch;
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    cur_onehot   = NUM_TESTS'(1) << idx_q;
    test_start   = (state_q == StLaunch) ? cur_onehot : '0;
    test_busy    = (state_q == StWait) ? cur_onehot : '0;
    finish       = (state_q == StDone);
    pass         = (state_q == StDone) && (fail_q == '0);
    cur_idx      = idx_q;
    fail_mask    = fail_q;
    timeout_mask = tmo_q;
  end

endmodule

// File: tb/tb_tester_sequencer.sv
// Randomized bench for tester_sequencer: a timeline model predicts start/busy/index/mask/finish
// for every cycle of each scenario, on a stop-on-fail instance and a run-all instance.
module tb_tester_sequencer;

  localparam int N   = 4;
  localparam int TMO = 16;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         go_in     [2];
  logic [N-1:0] done_in   [2];
  logic [N-1:0] fail_in   [2];
  logic [N-1:0] start_w   [2];
  logic [N-1:0] busy_w    [2];
  logic [1:0]   idx_w     [2];
  logic         finish_w  [2];
  logic         pass_w    [2];
  logic [N-1:0] fmask_w   [2];
  logic [N-1:0] tmask_w   [2];

  int checks = 0;
  int errors = 0;
  int cur_t  = 0;

  // Per-scenario tester behaviour: done arrives lat[i] cycles after start (<0: never).
  int lat [N];
  bit fl  [N];

  always #5 clock = ~clock;

  tester_sequencer #(
    .NUM_TESTS(N), .IDX_W(2), .TIMEOUT(TMO), .CNT_W(4), .STOP_ON_FAIL(1'b1)
  ) u_sof (
    .clock(clock), .reset(reset), .go(go_in[0]),
    .test_start(start_w[0]), .test_busy(busy_w[0]),
    .test_done(done_in[0]), .test_fail(fail_in[0]),
    .cur_idx(idx_w[0]), .finish(finish_w[0]), .pass(pass_w[0]),
    .fail_mask(fmask_w[0]), .timeout_mask(tmask_w[0])
  );

  tester_sequencer #(
    .NUM_TESTS(N), .IDX_W(2), .TIMEOUT(TMO), .CNT_W(4), .STOP_ON_FAIL(1'b0)
  ) u_all (
    .clock(clock), .reset(reset), .go(go_in[1]),
    .test_start(start_w[1]), .test_busy(busy_w[1]),
    .test_done(done_in[1]), .test_fail(fail_in[1]),
    .cur_idx(idx_w[1]), .finish(finish_w[1]), .pass(pass_w[1]),
    .fail_mask(fmask_w[1]), .timeout_mask(tmask_w[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed %0h expected %0h", tag, cur_t, obs, exp);
    end
  endtask

  task automatic chk_all(input int sel, input logic [N-1:0] st, input logic [N-1:0] bz,
                         input logic [1:0] ix, input logic fin, input logic ps,
                         input logic [N-1:0] fm, input logic [N-1:0] tm);
    chk("test_start", start_w[sel], st);
    chk("test_busy", busy_w[sel], bz);
    chk("cur_idx", idx_w[sel], ix);
    chk("finish", finish_w[sel], fin);
    chk("pass", pass_w[sel], ps);
    chk("fail_mask", fmask_w[sel], fm);
    chk("timeout_mask", tmask_w[sel], tm);
  endtask

  // sel 0: stop-on-fail instance, sel 1: run-all instance. abort_t >= 0 asserts reset mid-run.
  task automatic run(input int sel, input bit do_reset, input int abort_t);
    int s [N];
    int e [N];
    logic [N-1:0] efm, etm, st, bz, fm, tm, d, f;
    logic [1:0] ix;
    int nrun, fin, t, last;
    bit sof;
    sof  = (sel == 0);
    efm  = '0;
    etm  = '0;
    nrun = 0;
    fin  = 0;
    t    = 1;
    for (int i = 0; i < N; i++) begin
      s[i] = t;
      if (lat[i] >= 1 && lat[i] <= TMO) begin
        e[i]   = t + lat[i];
        efm[i] = fl[i];
      end else begin
        e[i]   = t + TMO;
        efm[i] = 1'b1;
        etm[i] = 1'b1;
      end
      nrun = i + 1;
      if (i == N - 1 || (sof && efm[i])) begin
        fin = e[i] + 2;
        break;
      end
      t = e[i] + 2;
    end
    last = (abort_t >= 0) ? abort_t : fin + 2;

    if (do_reset) begin
      @(negedge clock);
      reset = 1'b1;
      #1;
      cur_t = -1;
      chk_all(sel, '0, '0, '0, 1'b0, 1'b0, '0, '0);
      @(negedge clock);
      reset = 1'b0;
    end

    for (int tc = 0; tc <= last; tc++) begin
      @(negedge clock);
      cur_t = tc;
      st = '0; bz = '0; ix = '0; fm = '0; tm = '0;
      for (int i = 0; i < nrun; i++) begin
        if (s[i] == tc) st[i] = 1'b1;
        if (s[i] < tc && tc <= e[i]) bz[i] = 1'b1;
        if (s[i] <= tc) ix = 2'(i);
        if (e[i] < tc) begin
          fm[i] = efm[i];
          tm[i] = etm[i];
        end
      end
      chk_all(sel, st, bz, ix, tc >= fin, (tc >= fin) && (efm == '0), fm, tm);

      // Inputs for this cycle: real done pulses plus noise outside each tester's own wait window.
      d = '0;
      f = N'($urandom);
      for (int j = 0; j < N; j++) begin
        bit in_win;
        in_win = (j < nrun) && (s[j] < tc) && (tc <= e[j]);
        if (j < nrun && lat[j] >= 0 && tc == s[j] + lat[j]) begin
          d[j] = 1'b1;
          f[j] = fl[j];
        end else if (!in_win && $urandom_range(0, 3) == 0) begin
          d[j] = 1'b1;
        end
      end
      done_in[sel] = d;
      fail_in[sel] = f;
      go_in[sel]   = (tc == 0) ? 1'b1 : 1'($urandom);
    end

    if (abort_t >= 0) begin
      #1;
      reset = 1'b1;
      #1;
      chk_all(sel, '0, '0, '0, 1'b0, 1'b0, '0, '0);
      @(negedge clock);
      reset = 1'b0;
    end
    done_in[sel] = '0;
    fail_in[sel] = '0;
    go_in[sel]   = 1'b0;
  endtask

  task automatic set_all(input int l, input bit f);
    for (int i = 0; i < N; i++) begin
      lat[i] = l;
      fl[i]  = f;
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      go_in[k]   = 1'b0;
      done_in[k] = '0;
      fail_in[k] = '0;
    end

    // All pass, done 3 cycles after each start.
    set_all(3, 1'b0);
    run(0, 1'b1, -1);
    run(1, 1'b1, -1);
    // Stop on first failure at test 1.
    set_all(3, 1'b0);
    fl[1] = 1'b1;
    run(0, 1'b1, -1);
    // Run-all with test 2 failing.
    set_all(3, 1'b0);
    fl[2] = 1'b1;
    run(1, 1'b1, -1);
    // Test 0 never answers: timeout then continue.
    set_all(3, 1'b0);
    lat[0] = -1;
    run(1, 1'b1, -1);
    run(0, 1'b1, -1);
    // Done on the last allowed cycle, one cycle late, and during the start cycle.
    set_all(3, 1'b0);
    lat[0] = TMO;
    lat[1] = TMO + 1;
    lat[2] = 0;
    run(1, 1'b1, -1);
    // Reset during WAIT of test 2, then restart without a further reset.
    set_all(3, 1'b0);
    run(1, 1'b1, 12);
    set_all(2, 1'b0);
    fl[3] = 1'b1;
    run(1, 1'b0, -1);

    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < N; i++) begin
        lat[i] = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TMO + 2));
        fl[i]  = ($urandom_range(0, 3) == 0);
      end
      run(n % 2, 1'b1, ($urandom_range(0, 5) == 0) ? int'($urandom_range(2, 30)) : -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
